// File: rtl/attitude_pkg.sv
// Shared definitions for the attitude classifier: code bit positions, reset code and axis states.
package attitude_pkg;

    localparam int ATT_ROLL_SGN  = 3;
    localparam int ATT_PITCH_SGN = 2;
    localparam int ATT_ROLL_LVL  = 1;
    localparam int ATT_PITCH_LVL = 0;

    localparam logic [3:0] ATT_RESET = 4'b0011;

    typedef enum logic {
        LEVEL  = 1'b0,
        TILTED = 1'b1
    } axis_state_t;

endpackage

// File: rtl/attitude_classifier_axis_level_tracker.sv
// One axis: saturating magnitude, whole-degree conversion, hysteresis FSM with debounce.
// ATT_TILT_ALARM_EN adds an above-alarm-threshold flag for the tilt alarm.
import attitude_pkg::*;

module axis_level_tracker #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 4,
    parameter int ENTER_DEG = 8,
    parameter int EXIT_DEG  = 12,
    parameter int DEBOUNCE  = 4,
`ifdef ATT_TILT_ALARM_EN
    parameter int ALARM_DEG = 45,
`endif
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [DATA_W-1:0] raw,
`ifdef ATT_TILT_ALARM_EN
    output logic              over_alarm,
`endif
    output logic              level_next
);
    localparam logic [DATA_W-1:0] ENTER_L  = DATA_W'(ENTER_DEG);
    localparam logic [DATA_W-1:0] EXIT_L   = DATA_W'(EXIT_DEG);
    localparam logic [CNT_W-1:0]  DEB_L    = CNT_W'(DEBOUNCE);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] deg;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
    logic              qualify;
    axis_state_t       state, state_next;

    // The most negative code has no positive twin, so clamp it instead of wrapping.
    always_comb begin
        if (raw == MOST_NEG)
            mag = MOST_POS;
        else if (raw[DATA_W-1])
            mag = -raw;
        else
            mag = raw;
    end

    assign deg = mag >> FRAC_BITS;

`ifdef ATT_TILT_ALARM_EN
    assign over_alarm = deg > DATA_W'(ALARM_DEG);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LEVEL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        qualify    = (state == LEVEL) ? (deg > EXIT_L) : (deg <= ENTER_L);
        cnt_inc    = cnt + 1'b1;
        if (valid) begin
            if (!qualify) begin
                cnt_next = '0;
            end else if (cnt_inc == DEB_L) begin
                state_next = (state == LEVEL) ? TILTED : LEVEL;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_inc;
            end
        end
    end

    always_comb begin
        level_next = (state_next == LEVEL);
    end

endmodule

// File: rtl/attitude_classifier.sv
// Clocked roll/pitch attitude encoder: sign bits pass straight through, level bits are debounced.
// ATT_TILT_ALARM_EN adds a sustained-tilt alarm output.
import attitude_pkg::*;

module attitude_classifier #(
    parameter int DATA_W        = 16,
    parameter int FRAC_BITS     = 4,
    parameter int ENTER_DEG     = 8,
    parameter int EXIT_DEG      = 12,
    parameter int DEBOUNCE      = 4,
`ifdef ATT_TILT_ALARM_EN
    parameter int ALARM_DEG     = 45,
    parameter int ALARM_SAMPLES = 8,
`endif
    parameter int CNT_W         = 3
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Valid,
    input  logic [DATA_W-1:0] i_Roll_Raw,
    input  logic [DATA_W-1:0] i_Pitch_Raw,
`ifdef ATT_TILT_ALARM_EN
    output logic              o_Alarm,
`endif
    output logic [3:0]        o_Attitude,
    output logic              o_Valid,
    output logic              o_Changed
);
    if (!(ENTER_DEG < EXIT_DEG && DEBOUNCE >= 1 && DEBOUNCE < (1 << CNT_W))) begin : g_param_check
        $fatal(1, "attitude_classifier: bad ENTER_DEG/EXIT_DEG/DEBOUNCE/CNT_W");
    end

    logic       roll_level, pitch_level;
    logic [3:0] code_next;

`ifdef ATT_TILT_ALARM_EN
    logic roll_over, pitch_over;
`endif

    axis_level_tracker #(
        .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ENTER_DEG(ENTER_DEG),
`ifdef ATT_TILT_ALARM_EN
        .ALARM_DEG(ALARM_DEG),
`endif
        .EXIT_DEG(EXIT_DEG), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)
    ) u_roll (
        .clk(i_Clk), .reset(i_Reset), .valid(i_Valid), .raw(i_Roll_Raw),
`ifdef ATT_TILT_ALARM_EN
        .over_alarm(roll_over),
`endif
        .level_next(roll_level)
    );

    axis_level_tracker #(
        .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ENTER_DEG(ENTER_DEG),
`ifdef ATT_TILT_ALARM_EN
        .ALARM_DEG(ALARM_DEG),
`endif
        .EXIT_DEG(EXIT_DEG), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)
    ) u_pitch (
        .clk(i_Clk), .reset(i_Reset), .valid(i_Valid), .raw(i_Pitch_Raw),
`ifdef ATT_TILT_ALARM_EN
        .over_alarm(pitch_over),
`endif
        .level_next(pitch_level)
    );

    always_comb begin
        code_next                = ATT_RESET;
        code_next[ATT_ROLL_SGN]  = i_Roll_Raw[DATA_W-1];
        code_next[ATT_PITCH_SGN] = i_Pitch_Raw[DATA_W-1];
        code_next[ATT_ROLL_LVL]  = roll_level;
        code_next[ATT_PITCH_LVL] = pitch_level;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Attitude <= ATT_RESET;
            o_Valid    <= 1'b0;
            o_Changed  <= 1'b0;
        end else if (i_Valid) begin
            o_Attitude <= code_next;
            o_Valid    <= 1'b1;
            o_Changed  <= (code_next != o_Attitude);
        end else begin
            o_Valid    <= 1'b0;
            o_Changed  <= 1'b0;
        end
    end

`ifdef ATT_TILT_ALARM_EN
    localparam int ACNT_W = $clog2(ALARM_SAMPLES + 1);
    localparam logic [ACNT_W-1:0] ALARM_L = ACNT_W'(ALARM_SAMPLES);

    logic [ACNT_W-1:0] alarm_cnt;

    // Count saturates so a long tilt holds the alarm without wrapping.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            alarm_cnt <= '0;
            o_Alarm   <= 1'b0;
        end else if (i_Valid) begin
            if (!(roll_over || pitch_over)) begin
                alarm_cnt <= '0;
                o_Alarm   <= 1'b0;
            end else if (alarm_cnt != ALARM_L) begin
                alarm_cnt <= alarm_cnt + 1'b1;
                o_Alarm   <= ((alarm_cnt + 1'b1) == ALARM_L);
            end
        end
    end
`endif

endmodule

// File: tb/tb_attitude_classifier.sv
// Directed bench for attitude_classifier; alarm vectors run when ATT_TILT_ALARM_EN is defined.
module tb_attitude_classifier;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] roll = '0;
    logic [15:0] pitch = '0;
    logic [3:0]  attitude;
    logic        out_valid;
    logic        changed;
    logic        alarm;

    int checks = 0;
    int errors = 0;

    // Entry layout: {alarm, changed, attitude}
    logic [5:0] exp_q[$];
    logic [3:0] prev_code;

    always #5 clk = ~clk;

    attitude_classifier dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Valid(valid),
        .i_Roll_Raw(roll),
        .i_Pitch_Raw(pitch),
`ifdef ATT_TILT_ALARM_EN
        .o_Alarm(alarm),
`endif
        .o_Attitude(attitude),
        .o_Valid(out_valid),
        .o_Changed(changed)
    );

`ifndef ATT_TILT_ALARM_EN
    assign alarm = 1'b0;
`endif

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        prev_code = 4'b0011;
        @(negedge clk);
        check("reset_state", {alarm, changed, attitude}, 6'b000011);
        check("reset_valid", {5'b0, out_valid}, 6'b0);
    endtask

    // Drives one valid sample; code and alarm are hand-computed by the caller.
    task automatic send(input logic [15:0] r, input logic [15:0] p,
                        input logic [3:0] code, input logic alm, input int idle);
        @(posedge clk); #1;
        roll = r; pitch = p; valid = 1'b1;
        exp_q.push_back({alm, (code != prev_code), code});
        prev_code = code;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (idle) @(posedge clk);
    endtask

    task automatic send_n(input int n, input logic [15:0] r, input logic [15:0] p,
                          input logic [3:0] code, input logic alm);
        for (int i = 0; i < n; i++) send(r, p, code, alm, 0);
    endtask

    // Monitor: every output pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=%b required=none", attitude);
                end else begin
                    check("output", {alarm, changed, attitude}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        prev_code = 4'b0011;
        do_reset();

        // Pitch negative, both level
        send(16'h0040, 16'hFFE0, 4'b0111, 1'b0, 0);

        // Roll -13 deg with gaps: commits on the 4th sample
        send(16'hFF30, 16'h0000, 4'b1011, 1'b0, 2);
        send(16'hFF30, 16'h0000, 4'b1011, 1'b0, 3);
        send(16'hFF30, 16'h0000, 4'b1011, 1'b0, 1);
        send(16'hFF30, 16'h0000, 4'b1001, 1'b0, 2);

        // Hysteresis band holds TILTED, 8 deg returns LEVEL, 12 deg keeps LEVEL
        send_n(10, 16'h00A0, 16'h0000, 4'b0001, 1'b0);
        send_n(3, 16'h0080, 16'h0000, 4'b0001, 1'b0);
        send(16'h0080, 16'h0000, 4'b0011, 1'b0, 0);
        send_n(4, 16'h00C0, 16'h0000, 4'b0011, 1'b0);

        // Debounce run broken by a 5 deg sample
        send_n(3, 16'h00D0, 16'h0000, 4'b0011, 1'b0);
        send(16'h0050, 16'h0000, 4'b0011, 1'b0, 0);
        send_n(3, 16'h00D0, 16'h0000, 4'b0011, 1'b0);
        send(16'h00D0, 16'h0000, 4'b0001, 1'b0, 0);

        // Most negative roll saturates and tilts
        do_reset();
        send_n(3, 16'h8000, 16'h0000, 4'b1011, 1'b0);
        send(16'h8000, 16'h0000, 4'b1001, 1'b0, 0);

        // Pitch axis on its own
        do_reset();
        send_n(3, 16'h0000, 16'h0100, 4'b0011, 1'b0);
        send(16'h0000, 16'h0100, 4'b0010, 1'b0, 0);

        // Reset together with valid discards a partial run
        do_reset();
        send_n(3, 16'h00D0, 16'h0000, 4'b0011, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; valid = 1'b1; roll = 16'h00D0;
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b0;
        prev_code = 4'b0011;
        @(negedge clk);
        check("reset_with_valid", {alarm, changed, attitude}, 6'b000011);
        check("reset_with_valid_ov", {5'b0, out_valid}, 6'b0);
        send_n(3, 16'h00D0, 16'h0000, 4'b0011, 1'b0);
        send(16'h00D0, 16'h0000, 4'b0001, 1'b0, 0);

`ifdef ATT_TILT_ALARM_EN
        // 50 deg roll: tilts after 4, alarm after 8; 0 deg clears alarm
        do_reset();
        send_n(3, 16'h0320, 16'h0000, 4'b0011, 1'b0);
        send_n(4, 16'h0320, 16'h0000, 4'b0001, 1'b0);
        send(16'h0320, 16'h0000, 4'b0001, 1'b1, 0);
        send(16'h0320, 16'h0000, 4'b0001, 1'b1, 0);
        send(16'h0000, 16'h0000, 4'b0001, 1'b0, 0);
`endif

        repeat (4) @(posedge clk);
        check("queue_drained", 6'(exp_q.size()), 6'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=done");
        $fatal(1, "timeout");
    end
endmodule
